// File: rtl/quad_enc_gen_pkg.sv
// Shared types and helpers for the quadrature encoder generator.
// Phase index 0..3 maps to {a,b} = 00, 10, 11, 01 (clockwise order).
package quad_enc_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int PH_W = 2;

    // Packed phase table, index 0 in the least significant pair.
    localparam logic [7:0] PHASE_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

    // Next phase index: CW steps forward, CCW steps backward, both modulo 4.
    function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] phase,
                                                   input logic dir);
        return dir ? phase + 2'd1 : phase - 2'd1;
    endfunction

    // {a,b} level pair for a phase index.
    function automatic logic [1:0] phase_ab(input logic [PH_W-1:0] idx);
        logic [7:0] tbl;
        tbl = PHASE_TABLE;
        return tbl[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/quad_enc_tick.sv
// Loadable down-counter that paces the phase advances.
// expire is high in any enabled cycle where the count has reached zero;
// the owner reloads it with load on that same cycle.
module quad_enc_tick #(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             enable,
    output logic             expire
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Load has priority; otherwise count down while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder generator: turns a (dir, steps, period) command into a
// Gray-coded A/B pair and tracks a signed running position.
// Optional build macro QUAD_ENC_GEN_ABORT_EN adds an abort input that ends a
// running command early, keeping a/b and pos where they are.
module quad_enc_gen
    import quad_enc_gen_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DIV_W = 12,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
`ifdef QUAD_ENC_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [1:0]        ab_q, ab_d;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  reload_q, reload_d;
    logic [POS_W-1:0]  pos_q, pos_d;

    logic              tick_load;
    logic [DIV_W-1:0]  tick_load_val;
    logic              tick_en;
    logic              tick_expire;
    logic [DIV_W-1:0]  period_reload;

    // A period of 0 behaves as 1, so the reload value saturates at 0.
    assign period_reload = (period == '0) ? '0 : period - DIV_W'(1);

    quad_enc_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (tick_load),
        .load_val (tick_load_val),
        .enable   (tick_en),
        .expire   (tick_expire)
    );

    // Next-state logic: command capture, phase advance and completion.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        ab_d          = ab_q;
        dir_d         = dir_q;
        rem_d         = rem_q;
        reload_d      = reload_q;
        pos_d         = pos_q;
        tick_load     = 1'b0;
        tick_load_val = reload_q;
        tick_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        dir_d         = dir;
                        rem_d         = steps;
                        reload_d      = period_reload;
                        tick_load     = 1'b1;
                        tick_load_val = period_reload;
                        state_d       = RUN;
                    end else begin
                        // Empty command: acknowledge without touching a/b.
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                tick_en = 1'b1;
                if (tick_expire) begin
                    phase_d   = next_phase(phase_q, dir_q);
                    ab_d      = phase_ab(phase_d);
                    pos_d     = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    rem_d     = rem_q - CNT_W'(1);
                    tick_load = 1'b1;
                    // Last advance and the move to DONE share one edge.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
`ifdef QUAD_ENC_GEN_ABORT_EN
                // An advance due on this edge still happens; then stop.
                if (abort) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            ab_q     <= 2'b00;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            reload_q <= '0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ab_q     <= ab_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            reload_q <= reload_d;
            pos_q    <= pos_d;
        end
    end

    assign a    = ab_q[1];
    assign b    = ab_q[0];
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign pos  = pos_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen. Each command pushes its expected a/b
// edges (level, position, edge number) and done edge into queues; a monitor
// sampling 1 ns after each rising edge pops and compares them.
module tb_quad_enc_gen;

    typedef struct {
        logic [1:0]  ab;
        logic [15:0] pos;
        int          edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [7:0]  steps;
    logic [11:0] period;
`ifdef QUAD_ENC_GEN_ABORT_EN
    logic        abort;
`endif
    logic        a, b, busy, done;
    logic [15:0] pos;

    exp_t        edge_q[$];
    int          done_q[$];
    int          edge_n = 0;
    int          busy_n = 0;
    int          busy_base = 0;
    int          busy_exp = 0;
    logic [1:0]  prev_ab = 2'b00;
    int          errors = 0;
    int          checks = 0;

    // Bench-side reference state.
    int          m_ph = 0;
    logic [15:0] m_pos = 16'h0000;
    logic [1:0]  ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_enc_gen dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dir    (dir),
        .steps  (steps),
        .period (period),
`ifdef QUAD_ENC_GEN_ABORT_EN
        .abort  (abort),
`endif
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    // Monitor: one line per observed a/b edge or done pulse.
    always @(posedge clk) begin
        exp_t e;
        int   d;
        #1;
        edge_n++;
        if (rst) begin
            prev_ab = {a, b};
        end else begin
            if (busy) busy_n++;
            if ({a, b} !== prev_ab) begin
                checks++;
                assert (edge_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_edge: ab=%b at edge %0d, required no edge", {a, b}, edge_n);
                end
                if (edge_q.size() != 0) begin
                    e = edge_q.pop_front();
                    $display("edge %0d: ab=%b pos=%h (expected ab=%b pos=%h at edge %0d)",
                             edge_n, {a, b}, pos, e.ab, e.pos, e.edge_no);
                    checks++;
                    assert ({a, b} === e.ab) else begin
                        errors++;
                        $error("FAIL edge_ab: got %b, required %b", {a, b}, e.ab);
                    end
                    checks++;
                    assert (pos === e.pos) else begin
                        errors++;
                        $error("FAIL edge_pos: got %h, required %h", pos, e.pos);
                    end
                    checks++;
                    assert (edge_n === e.edge_no) else begin
                        errors++;
                        $error("FAIL edge_time: got edge %0d, required edge %0d", edge_n, e.edge_no);
                    end
                end
                prev_ab = {a, b};
            end
            if (done) begin
                checks++;
                assert (done_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_done: done=1 at edge %0d, required 0", edge_n);
                end
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    $display("done at edge %0d (expected edge %0d)", edge_n, d);
                    checks++;
                    assert (edge_n === d) else begin
                        errors++;
                        $error("FAIL done_time: got edge %0d, required edge %0d", edge_n, d);
                    end
                end
            end
        end
    end

    // Drive one command and queue every edge it should produce.
    task automatic start_cmd(input logic d, input int n, input int p);
        int   pe;
        int   t;
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        dir    = d;
        steps  = n[7:0];
        period = p[11:0];
        t  = edge_n + 1;
        pe = (p == 0) ? 1 : p;
        for (int k = 1; k <= n; k++) begin
            m_ph  = d ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
            m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
            e.ab      = ab_tbl[m_ph];
            e.pos     = m_pos;
            e.edge_no = t + k * pe;
            edge_q.push_back(e);
        end
        done_q.push_back(t + n * pe);
        busy_base = busy_n;
        busy_exp  = n * pe;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full command with bounded wait; optionally spam start while busy/done.
    task automatic run_cmd(input logic d, input int n, input int p, input bit spam);
        bit ok;
        ok = 1'b0;
        start_cmd(d, n, p);
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (edge_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
            end
            if (spam) begin
                start  = 1'b1;
                dir    = ~d;
                steps  = 8'd3;
                period = 12'd1;
            end
        end
        if (spam) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL cmd_timeout: %0d edges and %0d done pulses outstanding, required 0",
                   edge_q.size(), done_q.size());
        end
        checks++;
        assert ((busy_n - busy_base) === busy_exp) else begin
            errors++;
            $error("FAIL busy_cycles: got %0d, required %0d", busy_n - busy_base, busy_exp);
        end
        checks++;
        assert (pos === m_pos) else begin
            errors++;
            $error("FAIL cmd_pos: got %h, required %h", pos, m_pos);
        end
        checks++;
        assert ({a, b, busy} === {ab_tbl[m_ph], 1'b0}) else begin
            errors++;
            $error("FAIL cmd_end: got ab/busy=%b, required %b", {a, b, busy}, {ab_tbl[m_ph], 1'b0});
        end
    endtask

    initial begin
        bit reached;
        rst    = 1'b1;
        start  = 1'b0;
        dir    = 1'b0;
        steps  = 8'd0;
        period = 12'd0;
`ifdef QUAD_ENC_GEN_ABORT_EN
        abort  = 1'b0;
`endif
        @(negedge clk);
        checks++;
        assert ({a, b, busy, done} === 4'b0000) else begin
            errors++;
            $error("FAIL reset_ctl: got a/b/busy/done=%b, required 0000", {a, b, busy, done});
        end
        checks++;
        assert (pos === 16'h0000) else begin
            errors++;
            $error("FAIL reset_pos: got %h, required 0000", pos);
        end
        @(negedge clk);
        rst = 1'b0;

        // CW, 4 steps, 3 cycles per phase.
        run_cmd(1'b1, 4, 3, 1'b0);
        checks++;
        assert ({pos, a, b} === {16'd4, 2'b00}) else begin
            errors++;
            $error("FAIL cw4_final: got pos=%h ab=%b, required 0004 00", pos, {a, b});
        end

        // CCW, 6 steps, one phase per cycle; passes through 0 into negatives.
        run_cmd(1'b0, 6, 1, 1'b0);
        checks++;
        assert ({pos, a, b} === {16'hFFFE, 2'b11}) else begin
            errors++;
            $error("FAIL ccw6_final: got pos=%h ab=%b, required fffe 11", pos, {a, b});
        end

        // Zero steps: done only, no edge.
        run_cmd(1'b1, 0, 5, 1'b0);
        // Period 0 behaves as period 1.
        run_cmd(1'b1, 2, 0, 1'b0);
        // Start spammed during RUN and DONE must be ignored.
        run_cmd(1'b0, 3, 2, 1'b1);
        // Nothing more may happen after the spammed command.
        repeat (6) @(negedge clk);

        // Reset after 2 of 5 steps: everything clears, no done.
        start_cmd(1'b1, 5, 2);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (edge_q.size() <= 3) reached = 1'b1;
        end
        checks++;
        assert (reached === 1'b1) else begin
            errors++;
            $error("FAIL midrun_wait: %0d edges outstanding, required 3", edge_q.size());
        end
        rst = 1'b1;
        edge_q.delete();
        done_q.delete();
        m_ph  = 0;
        m_pos = 16'h0000;
        #1;
        checks++;
        assert ({a, b, busy, done, pos} === {4'b0000, 16'h0000}) else begin
            errors++;
            $error("FAIL midrun_reset: got a/b/busy/done=%b pos=%h, required 0000 0000",
                   {a, b, busy, done}, pos);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

`ifdef QUAD_ENC_GEN_ABORT_EN
        // Abort in the cycle after the 3rd edge of a 10-step command.
        start_cmd(1'b1, 10, 4);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (edge_q.size() <= 7) reached = 1'b1;
        end
        abort = 1'b1;
        edge_q.delete();
        done_q.delete();
        done_q.push_back(edge_n + 1);
        m_ph  = 3;
        m_pos = 16'd3;
        @(negedge clk);
        abort = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        assert ((reached === 1'b1) && (done_q.size() == 0)) else begin
            errors++;
            $error("FAIL abort_done: %0d done pulses outstanding, required 0", done_q.size());
        end
        checks++;
        assert ({pos, a, b, busy} === {16'd3, 2'b01, 1'b0}) else begin
            errors++;
            $error("FAIL abort_hold: got pos=%h ab=%b busy=%b, required 0003 01 0", pos, {a, b}, busy);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
